dm_resp: RTL

DM_RESP -- requirements
Module: dm_resp

---
 rtl/dm_resp.sv | 74 +++++++
 1 files changed

// File: rtl/dm_resp.sv
// dm_resp: byte-lane data memory with one-cycle load response, extension and fault reporting
module dm_resp #(
  parameter int          DEPTH = 3072,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  byteen,
  input  logic [2:0]  ld_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [31:0]   offs;
  logic [AW-1:0] idx;
  logic          oor, ld_ok, be_ok, is_wr, is_ld, bad_mix, fault, do_wr, do_ld;
  logic [31:0]   q_word;
  logic [1:0]    q_off;
  logic [2:0]    q_sel;
  logic          q_valid;
  logic [15:0]   hw;
  logic [7:0]    b;
  always_comb begin
    offs    = addr - BASE;
    idx     = offs[AW+1:2];
    oor     = {2'b00, offs[31:2]} >= 32'(DEPTH);
    ld_ok   = ld_sel inside {[3'd1:3'd5]};
    be_ok   = byteen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    is_wr   = |byteen && !ld_ok;
    is_ld   = !(|byteen) && ld_ok;
    bad_mix = |byteen && ld_ok;
    fault   = req && (is_wr || is_ld || bad_mix) &&
              (oor || bad_mix || (ld_sel == 3'd1 && |offs[1:0]) ||
               ((ld_sel == 3'd2 || ld_sel == 3'd3) && offs[0]) || (|byteen && !be_ok));
    do_wr   = req && is_wr && !fault;
    do_ld   = req && is_ld && !fault;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      for (int i = 0; i < 4; i++)
        if (byteen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      q_valid <= do_ld;
      err     <= fault;
    end
    if (do_ld) q_word <= mem[idx];
    q_off <= offs[1:0];
    q_sel <= ld_sel;
  end
  always_comb begin
    hw     = q_off[1] ? q_word[31:16] : q_word[15:0];
    b      = q_off[0] ? hw[15:8] : hw[7:0];
    rvalid = q_valid;
    rdata  = !q_valid        ? '0 :
             q_sel == 3'd1   ? q_word :
             q_sel == 3'd2   ? {{16{hw[15]}}, hw} :
             q_sel == 3'd3   ? {16'b0, hw} :
             q_sel == 3'd4   ? {{24{b[7]}}, b} :
                               {24'b0, b};
  end
endmodule
